// File: rtl/per_xfer_ctrl_if.sv
// Serial peripheral bus between per_xfer_ctrl (master) and the attached peripheral (slave).
interface per_xfer_ctrl_if;
  logic sclk;
  logic cs_n;
  logic sdo;
  logic sdi;

  modport master (output sclk, output cs_n, output sdo, input sdi);
  modport slave  (input sclk, input cs_n, input sdo, output sdi);
endinterface

// File: rtl/per_xfer_ctrl.sv
// Serial frame transfer controller: shifts {addr, data} out MSB first on a divided sclk.
// Optional read-back of sdi into rdata is enabled with macro PER_XFER_READBACK_EN.
module per_xfer_ctrl #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startbit,
  input  logic                  resetbit,
  input  logic                  it_enable,
  input  logic [DATA_WIDTH-1:0] per_addr,
  input  logic [DATA_WIDTH-1:0] per_data,
  input  logic                  irq_clr,
  per_xfer_ctrl_if.master       spi,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned FRAME = ADDR_BITS + DATA_WIDTH;
  localparam int unsigned CntW  = $clog2(FRAME);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

  state_e             state_q;
  logic               start_q;
  logic [7:0]         div_cnt_q;
  logic [CntW-1:0]    bit_cnt_q;
  logic [FRAME-1:0]   shreg_q;
  logic               sclk_q, cs_n_q, sdo_q, busy_q, done_q, irq_q;

  logic start_edge;
  logic div_last;
  logic unused_addr;

  assign start_edge  = startbit & ~start_q;
  assign div_last    = (div_cnt_q == 8'(CLK_DIV - 1));
  assign unused_addr = ^per_addr;

`ifdef PER_XFER_READBACK_EN
  logic [DATA_WIDTH-1:0] rdata_q;
  assign rdata = rdata_q;
`else
  logic unused_sdi;
  assign unused_sdi = spi.sdi;
  assign rdata      = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
`ifdef PER_XFER_READBACK_EN
      rdata_q   <= '0;
`endif
    end else begin
      start_q <= startbit;
      done_q  <= 1'b0;
      if (resetbit) begin
        state_q   <= StIdle;
        div_cnt_q <= '0;
        sclk_q    <= 1'b0;
        cs_n_q    <= 1'b1;
        sdo_q     <= 1'b0;
        busy_q    <= 1'b0;
        irq_q     <= 1'b0;
      end else begin
        if (irq_clr) irq_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (start_edge) begin
              shreg_q   <= {per_addr[ADDR_BITS-1:0], per_data};
              sdo_q     <= per_addr[ADDR_BITS-1];
              cs_n_q    <= 1'b0;
              busy_q    <= 1'b1;
              div_cnt_q <= '0;
              state_q   <= StSetup;
            end
          end
          StSetup: begin
            if (div_last) begin
              div_cnt_q <= '0;
              bit_cnt_q <= CntW'(FRAME - 1);
              sdo_q     <= shreg_q[FRAME-1];
              state_q   <= StShift;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          StShift: begin
            if (div_last) begin
              div_cnt_q <= '0;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
`ifdef PER_XFER_READBACK_EN
                // Only the data part of the frame carries read-back bits.
                if (32'(bit_cnt_q) < DATA_WIDTH) rdata_q <= {rdata_q[DATA_WIDTH-2:0], spi.sdi};
`endif
              end else begin
                sclk_q <= 1'b0;
                if (bit_cnt_q == '0) begin
                  state_q <= StHold;
                end else begin
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  shreg_q   <= {shreg_q[FRAME-2:0], 1'b0};
                  sdo_q     <= shreg_q[FRAME-2];
                end
              end
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          StHold: begin
            if (div_last) begin
              div_cnt_q <= '0;
              busy_q    <= 1'b0;
              cs_n_q    <= 1'b1;
              sdo_q     <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          StDone: begin
            // Set is applied after the clear above so a coincident irq_clr loses.
            if (it_enable) irq_q <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spi.sclk = sclk_q;
  assign spi.cs_n = cs_n_q;
  assign spi.sdo  = sdo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_per_xfer_ctrl.sv
// Directed self-checking bench for per_xfer_ctrl with default parameters.
module tb_per_xfer_ctrl;

  logic        clk;
  logic        reset;
  logic        startbit;
  logic        resetbit;
  logic        it_enable;
  logic [31:0] per_addr;
  logic [31:0] per_data;
  logic        irq_clr;
  logic        busy;
  logic        done;
  logic        irq;
  logic [31:0] rdata;

  per_xfer_ctrl_if spi_bus ();

  per_xfer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .startbit  (startbit),
    .resetbit  (resetbit),
    .it_enable (it_enable),
    .per_addr  (per_addr),
    .per_data  (per_data),
    .irq_clr   (irq_clr),
    .spi       (spi_bus),
    .busy      (busy),
    .done      (done),
    .irq       (irq),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          sclk_pulses = 0;
  int          done_cnt = 0;
  int          busy_cycles = 0;
  int          bit_idx = 0;
  bit          sclk_prev = 1'b0;
  logic [63:0] sdo_bits = '0;
  logic [31:0] rd_word = 32'h1234_5678;
  logic [31:0] exp_rdata;
  int          p0, d0, b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model: counts sclk rises, records sdo, returns rd_word on the data bits.
  always @(negedge clk) begin
    if (spi_bus.sclk && !sclk_prev) begin
      sclk_pulses++;
      bit_idx++;
      sdo_bits = {sdo_bits[62:0], spi_bus.sdo};
    end
    if (spi_bus.cs_n) bit_idx = 0;
    sclk_prev = spi_bus.sclk;
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (bit_idx >= 8 && bit_idx < 40) spi_bus.sdi = rd_word[39-bit_idx];
    else spi_bus.sdi = 1'b0;
  end

  task automatic snap();
    p0 = sclk_pulses;
    d0 = done_cnt;
    b0 = busy_cycles;
  endtask

  task automatic start_xfer();
    @(negedge clk);
    startbit = 1'b1;
    @(negedge clk);
    startbit = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check_eq({tag, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_pulses(input string tag, input int target);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sclk_pulses >= target) return;
    end
    check_eq({tag, "_pulse_timeout"}, 64'(sclk_pulses), 64'(target));
  endtask

  initial begin
`ifdef PER_XFER_READBACK_EN
    exp_rdata = 32'h1234_5678;
`else
    exp_rdata = 32'h0;
`endif
    reset     = 1'b1;
    startbit  = 1'b0;
    resetbit  = 1'b0;
    it_enable = 1'b0;
    irq_clr   = 1'b0;
    per_addr  = '0;
    per_data  = '0;
    spi_bus.sdi = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 64'(spi_bus.sclk), 64'd0);
    check_eq("rst_cs_n", 64'(spi_bus.cs_n), 64'd1);
    check_eq("rst_sdo", 64'(spi_bus.sdo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, interrupts disabled.
    per_addr = 32'h5A;
    per_data = 32'hDEAD_BEEF;
    snap();
    start_xfer();
    wait_done("t1");
    repeat (5) @(negedge clk);
    check_eq("t1_pulses", 64'(sclk_pulses - p0), 64'd40);
    check_eq("t1_sdo", {24'h0, sdo_bits[39:0]}, 64'h5A_DEAD_BEEF);
    check_eq("t1_busy_cycles", 64'(busy_cycles - b0), 64'd328);
    check_eq("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("t1_irq", 64'(irq), 64'd0);
    check_eq("t1_cs_n", 64'(spi_bus.cs_n), 64'd1);
    check_eq("t1_rdata", 64'(rdata), 64'(exp_rdata));

    // Interrupt set, clear, and clear coinciding with DONE.
    it_enable = 1'b1;
    start_xfer();
    wait_done("t2a");
    repeat (2) @(negedge clk);
    check_eq("t2_irq_set", 64'(irq), 64'd1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check_eq("t2_irq_clr", 64'(irq), 64'd0);
    start_xfer();
    wait_done("t2b");
    irq_clr = 1'b1;
    check_eq("t2_irq_pre_set", 64'(irq), 64'd0);
    @(negedge clk);
    irq_clr = 1'b0;
    check_eq("t2_set_wins", 64'(irq), 64'd1);

    // Second start edge while busy is ignored.
    per_addr = 32'h33;
    per_data = 32'h0BAD_F00D;
    snap();
    start_xfer();
    repeat (99) @(negedge clk);
    startbit = 1'b1;
    @(negedge clk);
    startbit = 1'b0;
    wait_done("t3");
    repeat (400) @(negedge clk);
    check_eq("t3_pulses", 64'(sclk_pulses - p0), 64'd40);
    check_eq("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("t3_busy_cycles", 64'(busy_cycles - b0), 64'd328);
    check_eq("t3_sdo", {24'h0, sdo_bits[39:0]}, 64'h33_0BAD_F00D);

    // Soft reset in the middle of the frame.
    check_eq("t4_irq_pre", 64'(irq), 64'd1);
    per_addr = 32'hC3;
    per_data = 32'h55AA_00FF;
    snap();
    start_xfer();
    wait_pulses("t4", p0 + 20);
    resetbit = 1'b1;
    @(negedge clk);
    check_eq("t4_cs_n", 64'(spi_bus.cs_n), 64'd1);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_irq", 64'(irq), 64'd0);
    check_eq("t4_sclk", 64'(spi_bus.sclk), 64'd0);
    check_eq("t4_sdo", 64'(spi_bus.sdo), 64'd0);
    startbit = 1'b1;
    @(negedge clk);
    startbit = 1'b0;
    @(negedge clk);
    check_eq("t4_start_ignored", 64'(busy), 64'd0);
    resetbit = 1'b0;
    repeat (400) @(negedge clk);
    check_eq("t4_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("t4_idle_busy", 64'(busy), 64'd0);
    snap();
    start_xfer();
    wait_done("t4b");
    repeat (3) @(negedge clk);
    check_eq("t4b_pulses", 64'(sclk_pulses - p0), 64'd40);
    check_eq("t4b_sdo", {24'h0, sdo_bits[39:0]}, 64'hC3_55AA_00FF);
    check_eq("t4b_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("t4b_rdata", 64'(rdata), 64'(exp_rdata));
    check_eq("t4b_irq", 64'(irq), 64'd1);

    // Asynchronous reset between clock edges during SHIFT.
    start_xfer();
    wait_pulses("t5", sclk_pulses + 5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("t5_sclk", 64'(spi_bus.sclk), 64'd0);
    check_eq("t5_cs_n", 64'(spi_bus.cs_n), 64'd1);
    check_eq("t5_sdo", 64'(spi_bus.sdo), 64'd0);
    check_eq("t5_busy", 64'(busy), 64'd0);
    check_eq("t5_irq", 64'(irq), 64'd0);
    check_eq("t5_rdata", 64'(rdata), 64'd0);

    // startbit held high through reset release starts a transfer right away.
    startbit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    snap();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_busy", 64'(busy), 64'd1);
    startbit = 1'b0;
    wait_done("t6");
    repeat (3) @(negedge clk);
    check_eq("t6_pulses", 64'(sclk_pulses - p0), 64'd40);
    check_eq("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
